cic_comb_chain: RTL and testbench
=================================

// Module: cic_comb_chain
// PURPOSE
// Multi-stage CIC comb section for I/Q sample streams: NUM_STAGES cascaded combs y[n]=x[n]-x[n-DELAY].
// Sits ahead of the CIC interpolator integrators; replaces chains of single-stage combs.
// Adds per-stage bit growth, valid/ready flow control with backpressure, and a synchronous history flush.
// PARAMETERS
// WIDTH      16  input sample width per rail, two's complement
// NUM_STAGES 3   number of cascaded comb stages, 1..8
// DELAY      1   differential delay M per stage, 1..4
// OUT_WIDTH  WIDTH+NUM_STAGES (derived, localparam) output width per rail
// PORTS
// i_clock      in   1          clock
// i_reset_n    in   1          synchronous active-low reset
// i_clear      in   1          synchronous flush of histories and pipeline valids
// i_inph_data  in   WIDTH      input in-phase sample, signed
// i_quad_data  in   WIDTH      input quadrature sample, signed
// i_valid      in   1          input sample valid
// o_ready      out  1          block accepts input this cycle
// o_inph_data  out  OUT_WIDTH  output in-phase sample, signed
// o_quad_data  out  OUT_WIDTH  output quadrature sample, signed
// o_valid      out  1          output sample valid
// i_ready      in   1          downstream accepts output this cycle
// BEHAVIOUR
// - One clock: i_clock. Reset is synchronous and active-low on i_reset_n. Sampled on posedge i_clock only.
// - Reset (i_reset_n=0): all delay histories, stage registers, stage valids, o_valid, o_inph_data, o_quad_data -> 0.
// - i_clear=1 (reset inactive): same clearing as reset, in the same cycle; the input offered that cycle is discarded.
// - i_reset_n=0 has priority over i_clear.
// - Pipeline enable: en = !o_valid || i_ready. o_ready = en, combinational, and is 0 during reset.
// - Input accepted on a cycle with i_valid && o_ready.
// - Stage k (1..NUM_STAGES) is a registered comb with input width WIDTH+k-1 and output width WIDTH+k.
//   - Input is sign-extended by 1 bit before subtraction.
//   - Stage 1 input is the raw sample.
// - Stage k updates only when en=1 and its input valid is 1:
//   - The output register gets x - hist[DELAY-1].
//   - The history shifts: hist[0] <= x, hist[j] <= hist[j-1].
//   - The stage valid is set.
// - When en=1 and the stage input valid is 0: the stage valid clears, and the history and data hold.
// - When en=0: every stage register, valid and history holds. No sample is lost or duplicated.
// - Latency: NUM_STAGES cycles from acceptance to o_valid, with continuous i_ready=1. Throughput is 1 sample per cycle.
// - o_inph_data and o_quad_data hold stable while o_valid=1 and i_ready=0.
// - Empty history after reset or clear reads as zero. The first DELAY outputs per stage therefore equal the input (startup transient).
// - Histories advance only on valid samples. Bubbles in i_valid do not count toward DELAY.
// - Arithmetic is exact: +1 bit per stage, so no wrap-around is possible for any input, including -2^(WIDTH-1).
// - The I and Q rails are independent and identical, and share one valid pipeline.
// - Reset or clear mid-stream drops all in-flight samples. o_valid=0 on the next cycle.
// TESTING
// 1. Impulse, NUM_STAGES=3, DELAY=1, I=1 then zeros, i_ready=1 -> I outputs 1,-3,3,-1,0...; first output 3 cycles after accept.
// 2. DC step I=Q=100 continuous, NUM_STAGES=3, DELAY=2:
//    - The first 6 outputs are the binomial transient.
//    - Every output thereafter is 0.
// 3. Extreme input I=-32768, Q=32767 alternating with their negations (WIDTH=16):
//    - Outputs match the golden model at OUT_WIDTH=19 bits.
//    - No sign wrap occurs.
// 4. Backpressure: stream ramp 1,2,3..., then drop i_ready for 5 cycles mid-stream:
//    - o_ready=0 while o_valid=1.
//    - Output holds steady.
//    - The output sequence is unbroken vs the model.
// 5. Bubbles: i_valid toggles 1,0,0,1,... with ramp data -> output equals the model of the valid-only sequence; o_valid has matching gaps.
// 6. i_clear, then i_reset_n=0, each asserted for one cycle mid-stream:
//    - In-flight outputs are dropped.
//    - The next impulse reproduces scenario 1 exactly (histories are zero).

Source files
------------

// File: rtl/cic_comb_chain.sv
// Cascaded CIC comb section for I/Q streams: NUM_STAGES combs y=x-x[n-DELAY],
// one bit of growth per stage, valid/ready flow control and synchronous flush.
//
// Ports:
//   i_clock, i_reset_n (sync, active-low), i_clear (sync flush)
//   i_inph_data/i_quad_data [WIDTH], i_valid, o_ready   : input handshake
//   o_inph_data/o_quad_data [OUT_WIDTH], o_valid, i_ready : output handshake
module cic_comb_chain #(
  parameter int WIDTH      = 16,
  parameter int NUM_STAGES = 3,
  parameter int DELAY      = 1,
  localparam int OUT_WIDTH = WIDTH + NUM_STAGES
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic                 i_clear,
  input  logic [WIDTH-1:0]     i_inph_data,
  input  logic [WIDTH-1:0]     i_quad_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic [OUT_WIDTH-1:0] o_inph_data,
  output logic [OUT_WIDTH-1:0] o_quad_data,
  output logic                 o_valid,
  input  logic                 i_ready
);

  // Every stage is held at the final width, sign-extended. Stage k only
  // ever carries WIDTH+k significant bits, so results are bit-exact.
  logic [OUT_WIDTH-1:0]  xi [NUM_STAGES];
  logic [OUT_WIDTH-1:0]  xq [NUM_STAGES];
  logic [NUM_STAGES-1:0] vin;

  logic [OUT_WIDTH-1:0]  di_q [NUM_STAGES];
  logic [OUT_WIDTH-1:0]  di_d [NUM_STAGES];
  logic [OUT_WIDTH-1:0]  dq_q [NUM_STAGES];
  logic [OUT_WIDTH-1:0]  dq_d [NUM_STAGES];
  logic [NUM_STAGES-1:0] vld_q;
  logic [NUM_STAGES-1:0] vld_d;

  logic [OUT_WIDTH-1:0]  hi_q [NUM_STAGES][DELAY];
  logic [OUT_WIDTH-1:0]  hi_d [NUM_STAGES][DELAY];
  logic [OUT_WIDTH-1:0]  hq_q [NUM_STAGES][DELAY];
  logic [OUT_WIDTH-1:0]  hq_d [NUM_STAGES][DELAY];

  logic en;

  // The whole pipeline advances together, so a stall never
  // loses or duplicates a sample.
  assign en      = !vld_q[NUM_STAGES-1] || i_ready;
  assign o_ready = i_reset_n && en;

  assign o_inph_data = di_q[NUM_STAGES-1];
  assign o_quad_data = dq_q[NUM_STAGES-1];
  assign o_valid     = vld_q[NUM_STAGES-1];

  always_comb begin
    xi[0]  = {{NUM_STAGES{i_inph_data[WIDTH-1]}}, i_inph_data};
    xq[0]  = {{NUM_STAGES{i_quad_data[WIDTH-1]}}, i_quad_data};
    vin[0] = i_valid;
    for (int k = 1; k < NUM_STAGES; k++) begin
      xi[k]  = di_q[k-1];
      xq[k]  = dq_q[k-1];
      vin[k] = vld_q[k-1];
    end
  end

  always_comb begin
    di_d  = di_q;
    dq_d  = dq_q;
    hi_d  = hi_q;
    hq_d  = hq_q;
    vld_d = vld_q;
    if (en) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        if (vin[k]) begin
          di_d[k] = xi[k] - hi_q[k][DELAY-1];
          dq_d[k] = xq[k] - hq_q[k][DELAY-1];
          // History moves only on valid samples; bubbles do not age it.
          for (int j = DELAY - 1; j > 0; j--) begin
            hi_d[k][j] = hi_q[k][j-1];
            hq_d[k][j] = hq_q[k][j-1];
          end
          hi_d[k][0] = xi[k];
          hq_d[k][0] = xq[k];
          vld_d[k]   = 1'b1;
        end else begin
          vld_d[k] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n || i_clear) begin
      vld_q <= '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
        di_q[k] <= '0;
        dq_q[k] <= '0;
        for (int j = 0; j < DELAY; j++) begin
          hi_q[k][j] <= '0;
          hq_q[k][j] <= '0;
        end
      end
    end else begin
      vld_q <= vld_d;
      di_q  <= di_d;
      dq_q  <= dq_d;
      hi_q  <= hi_d;
      hq_q  <= hq_d;
    end
  end

endmodule

// File: tb/tb_cic_comb_chain.sv
// Bench for cic_comb_chain: DELAY=1 and DELAY=2 instances driven in lockstep,
// checked against a binomial-sum reference plus directed vector tables.
module tb_cic_comb_chain;

  localparam int W  = 16;
  localparam int NS = 3;
  localparam int OW = W + NS;

  logic clk = 1'b0;
  logic rst_n, clr, vi, ir;
  logic signed [W-1:0]  di, dq;
  logic                 or1, ov1, or2, ov2;
  logic signed [OW-1:0] oi1, oq1, oi2, oq2;

  always #5 clk = ~clk;

  cic_comb_chain #(.WIDTH(W), .NUM_STAGES(NS), .DELAY(1)) dut1 (
    .i_clock(clk), .i_reset_n(rst_n), .i_clear(clr),
    .i_inph_data(di), .i_quad_data(dq), .i_valid(vi), .o_ready(or1),
    .o_inph_data(oi1), .o_quad_data(oq1), .o_valid(ov1), .i_ready(ir)
  );

  cic_comb_chain #(.WIDTH(W), .NUM_STAGES(NS), .DELAY(2)) dut2 (
    .i_clock(clk), .i_reset_n(rst_n), .i_clear(clr),
    .i_inph_data(di), .i_quad_data(dq), .i_valid(vi), .o_ready(or2),
    .o_inph_data(oi2), .o_quad_data(oq2), .o_valid(ov2), .i_ready(ir)
  );

  typedef struct {
    logic signed [W-1:0] i;
    logic signed [W-1:0] q;
    int ei;
    int eq;
  } vec_t;

  typedef struct {
    int i;
    int q;
  } pair_t;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  int acc_cyc = -1;
  int ov_cyc  = -1;
  bit lat_arm = 1'b0;
  bit flush_prev = 1'b0;
  bit hold_prev  = 1'b0;
  int hold_i, hold_q;

  int    hi[$];
  int    hq[$];
  pair_t sb1[$];
  pair_t sb2[$];
  pair_t tq1[$];
  pair_t tq2[$];

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // y[n] = sum_j (-1)^j C(NS,j) x[n-j*m], zero before the first sample.
  function automatic int cref(input int h[$], input int m);
    int n = h.size() - 1;
    int c = 1;
    int y = 0;
    for (int j = 0; j <= NS; j++) begin
      if (n - j * m >= 0)
        y += ((j % 2) != 0 ? -c : c) * h[n - j * m];
      c = c * (NS - j) / (j + 1);
    end
    return y;
  endfunction

  always @(negedge clk) begin
    pair_t e;
    cyc++;
    if (flush_prev) begin
      chk("flush_ov1", int'(ov1), 0);
      chk("flush_ov2", int'(ov2), 0);
      chk("flush_oi1", int'(oi1), 0);
      chk("flush_oq2", int'(oq2), 0);
    end
    if (!rst_n) chk("rst_ordy", int'(or1), 0);
    if (!rst_n || clr) begin
      sb1.delete(); sb2.delete();
      tq1.delete(); tq2.delete();
      hi.delete();  hq.delete();
      hold_prev  = 1'b0;
      flush_prev = 1'b1;
    end else begin
      flush_prev = 1'b0;
      chk("ov_pair", int'(ov2), int'(ov1));
      if (hold_prev) begin
        chk("hold_ov", int'(ov1), 1);
        chk("hold_oi", int'(oi1), hold_i);
        chk("hold_oq", int'(oq1), hold_q);
      end
      if (ov1 && !ir) chk("bp_ordy", int'(or1), 0);
      hold_prev = ov1 && !ir;
      hold_i = int'(oi1);
      hold_q = int'(oq1);
      if (ov1 && ir) begin
        if (lat_arm && ov_cyc < 0) ov_cyc = cyc;
        if (sb1.size() == 0) chk("sb1_underflow", 1, 0);
        else begin
          e = sb1.pop_front();
          chk("d1_i", int'(oi1), e.i);
          chk("d1_q", int'(oq1), e.q);
        end
        if (sb2.size() == 0) chk("sb2_underflow", 1, 0);
        else begin
          e = sb2.pop_front();
          chk("d2_i", int'(oi2), e.i);
          chk("d2_q", int'(oq2), e.q);
        end
        if (tq1.size() > 0) begin
          e = tq1.pop_front();
          chk("tbl1_i", int'(oi1), e.i);
          chk("tbl1_q", int'(oq1), e.q);
        end
        if (tq2.size() > 0) begin
          e = tq2.pop_front();
          chk("tbl2_i", int'(oi2), e.i);
          chk("tbl2_q", int'(oq2), e.q);
        end
      end
      if (vi && or1) begin
        if (lat_arm && acc_cyc < 0) acc_cyc = cyc;
        hi.push_back(int'(di));
        hq.push_back(int'(dq));
        sb1.push_back('{cref(hi, 1), cref(hq, 1)});
        sb2.push_back('{cref(hi, 2), cref(hq, 2)});
      end
    end
  end

  task automatic send(input logic signed [W-1:0] a,
                      input logic signed [W-1:0] b);
    bit acc;
    int n = 0;
    vi = 1'b1; di = a; dq = b;
    do begin
      @(negedge clk);
      acc = or1 && rst_n && !clr;
      @(posedge clk); #1;
      n++;
      if (n > 50) begin
        chk("send_timeout", n, 0);
        acc = 1'b1;
      end
    end while (!acc);
    vi = 1'b0;
  endtask

  task automatic idle(input int n);
    vi = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  vec_t tbl[10];
  int   stp[10];

  initial begin
    tbl[0] = '{16'sd1,    -16'sd1,    1,      -1};
    tbl[1] = '{16'sd0,    16'sd0,     -3,     3};
    tbl[2] = '{16'sd0,    16'sd0,     3,      -3};
    tbl[3] = '{16'sd0,    16'sd0,     -1,     1};
    tbl[4] = '{16'sd0,    16'sd0,     0,      0};
    tbl[5] = '{16'sd0,    16'sd0,     0,      0};
    tbl[6] = '{16'sh8000, 16'sh7fff,  -32768, 32767};
    tbl[7] = '{16'sd0,    16'sd0,     98304,  -98301};
    tbl[8] = '{16'sd0,    16'sd0,     -98304, 98301};
    tbl[9] = '{16'sd0,    16'sd0,     32768,  -32767};
    stp = '{100, 100, -200, -200, 100, 100, 0, 0, 0, 0};

    rst_n = 1'b0; clr = 1'b0; vi = 1'b0; ir = 1'b1;
    di = '0; dq = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // impulse and extreme-value impulse, DELAY=1
    lat_arm = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tq1.push_back('{tbl[k].ei, tbl[k].eq});
      send(tbl[k].i, tbl[k].q);
    end
    idle(6);
    chk("latency", ov_cyc - acc_cyc, NS);
    lat_arm = 1'b0;

    // DC step on the DELAY=2 instance
    clr = 1'b1; @(posedge clk); #1 clr = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tq2.push_back('{stp[k], stp[k]});
      send(16'sd100, 16'sd100);
    end
    idle(6);

    // full-scale alternation
    for (int k = 0; k < 12; k++)
      send(k[0] ? 16'sh7fff : 16'sh8000, k[0] ? 16'sh8000 : 16'sh7fff);
    idle(6);

    // ramp with a 5-cycle downstream stall
    fork
      for (int k = 1; k <= 20; k++) send(16'(k), 16'(-k));
      begin
        repeat (8) @(posedge clk);
        #1 ir = 1'b0;
        repeat (5) @(posedge clk);
        #1 ir = 1'b1;
      end
    join
    idle(8);

    // bubbles: valid pattern 1,0,0
    for (int k = 1; k <= 12; k++) begin
      send(16'(k * 7), 16'(-k * 3));
      idle(2);
    end
    idle(6);

    // clear mid-stream, then impulse again
    for (int k = 0; k < 5; k++) send(16'(k + 50), 16'(k));
    clr = 1'b1; @(posedge clk); #1 clr = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tq1.push_back('{tbl[k].ei, tbl[k].eq});
      send(tbl[k].i, tbl[k].q);
    end
    idle(6);

    // reset mid-stream, then impulse again
    for (int k = 0; k < 5; k++) send(16'(-k - 90), 16'(k * 11));
    rst_n = 1'b0; @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tq1.push_back('{tbl[k].ei, tbl[k].eq});
      send(tbl[k].i, tbl[k].q);
    end
    idle(8);

    chk("sb_left", sb1.size() + sb2.size() + tq1.size() + tq2.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
